// File: rtl/mem_wb_if.sv
// -----------------------------------------------------------------------------
// mem_wb_if
// Data-memory bus between the memory/write-back stage (master) and the data
// memory (slave). One request is outstanding at a time: a request is accepted on
// mem_req_valid_o && mem_req_ready_i, and the matching completion arrives later
// on mem_rsp_valid_i.
//
// Signals:
//   mem_req_valid_o  master->slave  request valid
//   mem_req_ready_i  slave->master  request accepted this cycle
//   mem_addr_o       master->slave  doubleword-aligned address
//   mem_we_o         master->slave  1 = write
//   mem_wdata_o      master->slave  lane-shifted store data
//   mem_wmask_o      master->slave  byte-enable mask
//   mem_rsp_valid_i  slave->master  read/write completion
//   mem_rsp_rdata_i  slave->master  full doubleword read data
// -----------------------------------------------------------------------------
interface mem_wb_if #(
  parameter int XLEN = 64
);
  logic            mem_req_valid_o;
  logic            mem_req_ready_i;
  logic [XLEN-1:0] mem_addr_o;
  logic            mem_we_o;
  logic [XLEN-1:0] mem_wdata_o;
  logic [7:0]      mem_wmask_o;
  logic            mem_rsp_valid_i;
  logic [XLEN-1:0] mem_rsp_rdata_i;

  modport master (
    output mem_req_valid_o,
    output mem_addr_o,
    output mem_we_o,
    output mem_wdata_o,
    output mem_wmask_o,
    input  mem_req_ready_i,
    input  mem_rsp_valid_i,
    input  mem_rsp_rdata_i
  );

  modport slave (
    input  mem_req_valid_o,
    input  mem_addr_o,
    input  mem_we_o,
    input  mem_wdata_o,
    input  mem_wmask_o,
    output mem_req_ready_i,
    output mem_rsp_valid_i,
    output mem_rsp_rdata_i
  );
endinterface

// File: rtl/mem_wb.sv
// -----------------------------------------------------------------------------
// mem_wb
// Memory-access / write-back stage. Takes one retiring instruction from execute,
// performs its load or store over the data-memory bus, aligns and extends load
// data, and drives the register-file write port together with a one-cycle
// commit pulse carrying the retiring PC. Only XLEN = 64 is supported.
//
// Ports:
//   clk, rst        clock; synchronous active-low reset
//   ex_*            instruction handed over from execute (ex_valid_i/ex_ready_o
//                   handshake; ex_result_i is the effective address for memory ops)
//   bus             data-memory bus (mem_wb_if master side)
//   reg_waddr_o, reg_wdata_o, reg_wen_o   register-file write port
//   commit_o, commit_pc_o, misalign_o     retire pulse, its PC, misaligned flag
//
// All outputs are registered. The output process computes the value each output
// must carry in the *next* state, so the registered outputs line up exactly with
// the state register (e.g. commit_o is high precisely while the FSM is in WB).
// -----------------------------------------------------------------------------
module mem_wb #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,

  input  logic            ex_valid_i,
  output logic            ex_ready_o,
  input  logic [XLEN-1:0] ex_pc_i,
  input  logic [XLEN-1:0] ex_result_i,
  input  logic [4:0]      ex_rd_i,
  input  logic            ex_rd_wen_i,
  input  logic            ex_load_i,
  input  logic            ex_store_i,
  input  logic [2:0]      ex_funct3_i,
  input  logic [XLEN-1:0] ex_sdata_i,

  mem_wb_if.master        bus,

  output logic [4:0]      reg_waddr_o,
  output logic [XLEN-1:0] reg_wdata_o,
  output logic            reg_wen_o,
  output logic            commit_o,
  output logic [XLEN-1:0] commit_pc_o,
  output logic            misalign_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_WB   = 2'd3
  } state_t;

  // ---------------------------------------------------------------------------
  // Helper functions
  // ---------------------------------------------------------------------------

  // Natural alignment check; size is funct3[1:0] (byte/half/word/double).
  function automatic logic misaligned_f(input logic [2:0] off, input logic [1:0] size);
    logic mis;
    case (size)
      2'b00:   mis = 1'b0;
      2'b01:   mis = (off[0] != 1'b0);
      2'b10:   mis = (off[1:0] != 2'b00);
      2'b11:   mis = (off != 3'b000);
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

  // Byte-enable mask: base mask for the access size moved to the byte lane.
  function automatic logic [7:0] store_mask_f(input logic [2:0] off, input logic [1:0] size);
    logic [7:0] base;
    case (size)
      2'b00:   base = 8'h01;
      2'b01:   base = 8'h03;
      2'b10:   base = 8'h0F;
      2'b11:   base = 8'hFF;
      default: base = 8'h00;
    endcase
    return base << off;
  endfunction

  // Store data moved up to its byte lane; bytes above the access are don't-care
  // for the memory because the mask excludes them.
  function automatic logic [63:0] store_data_f(input logic [63:0] sdata, input logic [2:0] off);
    return sdata << {off, 3'b000};
  endfunction

  // Bring the addressed bytes down to bit 0, then sign/zero extend.
  function automatic logic [63:0] load_extract_f(input logic [63:0] rdata,
                                                 input logic [2:0]  off,
                                                 input logic [2:0]  funct3);
    logic [63:0] sh;
    logic [63:0] res;
    sh = rdata >> {off, 3'b000};
    case (funct3)
      3'b000:  res = {{56{sh[7]}},  sh[7:0]};
      3'b001:  res = {{48{sh[15]}}, sh[15:0]};
      3'b010:  res = {{32{sh[31]}}, sh[31:0]};
      3'b011:  res = sh;
      3'b100:  res = {56'd0, sh[7:0]};
      3'b101:  res = {48'd0, sh[15:0]};
      3'b110:  res = {32'd0, sh[31:0]};
      default: res = 64'd0;
    endcase
    return res;
  endfunction

  // ---------------------------------------------------------------------------
  // Declarations
  // ---------------------------------------------------------------------------
  state_t          state_r;
  state_t          state_next_s;

  // Instruction latched at the execute handshake
  logic [XLEN-1:0] pc_r;
  logic [4:0]      rd_r;
  logic            rd_wen_r;
  logic            load_r;
  logic            store_r;
  logic [2:0]      funct3_r;
  logic [2:0]      off_r;

  // Decode of the instruction currently offered by execute
  logic            accept_s;
  logic            ex_mem_s;
  logic            ex_misalign_s;

  // Registered outputs and their next values
  logic            ex_ready_r,  ex_ready_s;
  logic            req_valid_r, req_valid_s;
  logic [XLEN-1:0] addr_r,      addr_s;
  logic            we_r,        we_s;
  logic [XLEN-1:0] wdata_r,     wdata_s;
  logic [7:0]      wmask_r,     wmask_s;
  logic [4:0]      reg_waddr_r, reg_waddr_s;
  logic [XLEN-1:0] reg_wdata_r, reg_wdata_s;
  logic            reg_wen_r,   reg_wen_s;
  logic            commit_r,    commit_s;
  logic [XLEN-1:0] commit_pc_r, commit_pc_s;
  logic            misalign_r,  misalign_s;

  assign accept_s      = (state_r == ST_IDLE) && ex_valid_i;
  assign ex_mem_s      = ex_load_i || ex_store_i;
  assign ex_misalign_s = ex_mem_s && misaligned_f(ex_result_i[2:0], ex_funct3_i[1:0]);

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------

  // State register
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (ex_valid_i) begin
          // Non-memory and misaligned instructions never touch the bus
          if (!ex_mem_s || ex_misalign_s) begin
            state_next_s = ST_WB;
          end else begin
            state_next_s = ST_REQ;
          end
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (bus.mem_req_ready_i) begin
          state_next_s = ST_WAIT;
        end else begin
          state_next_s = ST_REQ;
        end
      end
      ST_WAIT: begin
        if (bus.mem_rsp_valid_i) begin
          state_next_s = ST_WB;
        end else begin
          state_next_s = ST_WAIT;
        end
      end
      ST_WB:   state_next_s = ST_IDLE;
      default: state_next_s = ST_IDLE;
    endcase
  end

  // Next output values, evaluated for the state being entered
  always_comb begin
    ex_ready_s  = (state_next_s == ST_IDLE);
    req_valid_s = (state_next_s == ST_REQ);
    commit_s    = (state_next_s == ST_WB);
    misalign_s  = 1'b0;
    reg_wen_s   = 1'b0;
    reg_waddr_s = reg_waddr_r;
    reg_wdata_s = reg_wdata_r;
    commit_pc_s = commit_pc_r;
    addr_s      = addr_r;
    we_s        = we_r;
    wdata_s     = wdata_r;
    wmask_s     = wmask_r;
    case (state_r)
      ST_IDLE: begin
        if (ex_valid_i) begin
          if (state_next_s == ST_WB) begin
            // Retire straight from IDLE: ALU result or misaligned access
            misalign_s  = ex_misalign_s;
            reg_waddr_s = ex_rd_i;
            reg_wdata_s = ex_result_i;
            commit_pc_s = ex_pc_i;
            reg_wen_s   = ex_rd_wen_i && !ex_store_i && !ex_misalign_s &&
                          (ex_rd_i != 5'd0);
          end else begin
            // Request fields are fixed here and held until the bus accepts
            addr_s  = {ex_result_i[XLEN-1:3], 3'b000};
            we_s    = ex_store_i;
            wdata_s = ex_store_i ? store_data_f(ex_sdata_i, ex_result_i[2:0]) : 64'd0;
            wmask_s = ex_store_i ? store_mask_f(ex_result_i[2:0], ex_funct3_i[1:0]) : 8'h00;
          end
        end else begin
          misalign_s = 1'b0;
        end
      end
      ST_WAIT: begin
        if (bus.mem_rsp_valid_i) begin
          reg_waddr_s = rd_r;
          commit_pc_s = pc_r;
          // Stores leave the write-data register untouched
          reg_wdata_s = load_r ? load_extract_f(bus.mem_rsp_rdata_i, off_r, funct3_r)
                               : reg_wdata_r;
          // funct3 111 is not a real load: it retires without writing
          reg_wen_s   = rd_wen_r && !store_r && (rd_r != 5'd0) &&
                        !(load_r && (funct3_r == 3'b111));
        end else begin
          reg_wen_s = 1'b0;
        end
      end
      ST_REQ:  misalign_s = 1'b0;
      ST_WB:   misalign_s = 1'b0;
      default: misalign_s = 1'b0;
    endcase
  end

  // Output registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      ex_ready_r  <= 1'b1;
      req_valid_r <= 1'b0;
      addr_r      <= '0;
      we_r        <= 1'b0;
      wdata_r     <= '0;
      wmask_r     <= 8'h00;
      reg_waddr_r <= 5'd0;
      reg_wdata_r <= '0;
      reg_wen_r   <= 1'b0;
      commit_r    <= 1'b0;
      commit_pc_r <= '0;
      misalign_r  <= 1'b0;
    end else begin
      ex_ready_r  <= ex_ready_s;
      req_valid_r <= req_valid_s;
      addr_r      <= addr_s;
      we_r        <= we_s;
      wdata_r     <= wdata_s;
      wmask_r     <= wmask_s;
      reg_waddr_r <= reg_waddr_s;
      reg_wdata_r <= reg_wdata_s;
      reg_wen_r   <= reg_wen_s;
      commit_r    <= commit_s;
      commit_pc_r <= commit_pc_s;
      misalign_r  <= misalign_s;
    end
  end

  // Instruction latch, loaded on the execute handshake
  always_ff @(posedge clk) begin
    if (!rst) begin
      pc_r     <= '0;
      rd_r     <= 5'd0;
      rd_wen_r <= 1'b0;
      load_r   <= 1'b0;
      store_r  <= 1'b0;
      funct3_r <= 3'b000;
      off_r    <= 3'b000;
    end else if (accept_s) begin
      pc_r     <= ex_pc_i;
      rd_r     <= ex_rd_i;
      rd_wen_r <= ex_rd_wen_i;
      load_r   <= ex_load_i;
      store_r  <= ex_store_i;
      funct3_r <= ex_funct3_i;
      off_r    <= ex_result_i[2:0];
    end else begin
      pc_r     <= pc_r;
      rd_r     <= rd_r;
      rd_wen_r <= rd_wen_r;
      load_r   <= load_r;
      store_r  <= store_r;
      funct3_r <= funct3_r;
      off_r    <= off_r;
    end
  end

  assign ex_ready_o          = ex_ready_r;
  assign bus.mem_req_valid_o = req_valid_r;
  assign bus.mem_addr_o      = addr_r;
  assign bus.mem_we_o        = we_r;
  assign bus.mem_wdata_o     = wdata_r;
  assign bus.mem_wmask_o     = wmask_r;
  assign reg_waddr_o         = reg_waddr_r;
  assign reg_wdata_o         = reg_wdata_r;
  assign reg_wen_o           = reg_wen_r;
  assign commit_o            = commit_r;
  assign commit_pc_o         = commit_pc_r;
  assign misalign_o          = misalign_r;

endmodule

// File: tb/tb_mem_wb.sv
// -----------------------------------------------------------------------------
// tb_mem_wb
// Self-checking bench for mem_wb. Each test pushes the expected retirement onto
// a scoreboard queue when it drives the instruction, plays the data memory by
// hand, and pops/compares when commit_o fires. Inputs change and outputs are
// sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_mem_wb;

  typedef struct {
    logic [63:0] pc;
    logic        wen;
    logic [4:0]  waddr;
    logic [63:0] wdata;
    logic        mis;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid;
  logic        ex_ready_o;
  logic [63:0] ex_pc;
  logic [63:0] ex_result;
  logic [4:0]  ex_rd;
  logic        ex_rd_wen;
  logic        ex_load;
  logic        ex_store;
  logic [2:0]  ex_funct3;
  logic [63:0] ex_sdata;
  logic [4:0]  reg_waddr_o;
  logic [63:0] reg_wdata_o;
  logic        reg_wen_o;
  logic        commit_o;
  logic [63:0] commit_pc_o;
  logic        misalign_o;

  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t sb[$];

  mem_wb_if #(.XLEN(64)) bus ();

  mem_wb #(.XLEN(64)) dut (
    .clk         (clk),
    .rst         (rst),
    .ex_valid_i  (ex_valid),
    .ex_ready_o  (ex_ready_o),
    .ex_pc_i     (ex_pc),
    .ex_result_i (ex_result),
    .ex_rd_i     (ex_rd),
    .ex_rd_wen_i (ex_rd_wen),
    .ex_load_i   (ex_load),
    .ex_store_i  (ex_store),
    .ex_funct3_i (ex_funct3),
    .ex_sdata_i  (ex_sdata),
    .bus         (bus),
    .reg_waddr_o (reg_waddr_o),
    .reg_wdata_o (reg_wdata_o),
    .reg_wen_o   (reg_wen_o),
    .commit_o    (commit_o),
    .commit_pc_o (commit_pc_o),
    .misalign_o  (misalign_o)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Byte-by-byte reference for load extraction.
  function automatic logic [63:0] model_load(logic [63:0] rdata, int off, logic [2:0] f3);
    logic [63:0] r;
    int n;
    logic sgn;
    r = 64'd0;
    if (f3 == 3'b111) return 64'd0;
    n = 1 << f3[1:0];
    for (int i = 0; i < n; i++) r[8*i +: 8] = rdata[8*(off+i) +: 8];
    sgn = (f3[2] == 1'b0) && r[8*n-1];
    for (int i = n; i < 8; i++) r[8*i +: 8] = sgn ? 8'hFF : 8'h00;
    return r;
  endfunction

  // Byte-by-byte reference for store lanes.
  function automatic logic [7:0] model_mask(int off, logic [2:0] f3);
    logic [7:0] m;
    int n;
    n = 1 << f3[1:0];
    m = 8'h00;
    for (int i = 0; i < 8; i++) if (i >= off && i < off + n) m[i] = 1'b1;
    return m;
  endfunction

  function automatic logic [63:0] model_wdata(logic [63:0] sdata, int off);
    logic [63:0] w;
    w = 64'd0;
    for (int i = 0; i < 8; i++) if (i >= off) w[8*i +: 8] = sdata[8*(i-off) +: 8];
    return w;
  endfunction

  // Drive one instruction for a single cycle once the stage is ready.
  task automatic issue(input logic [63:0] pc, input logic [63:0] res, input logic [4:0] rd,
                       input logic rd_wen, input logic ld, input logic st,
                       input logic [2:0] f3, input logic [63:0] sdata);
    for (int i = 0; i < 4 && ex_ready_o !== 1'b1; i++) @(negedge clk);
    ex_valid = 1'b1; ex_pc = pc; ex_result = res; ex_rd = rd; ex_rd_wen = rd_wen;
    ex_load = ld; ex_store = st; ex_funct3 = f3; ex_sdata = sdata;
    @(negedge clk);
    ex_valid = 1'b0; ex_load = 1'b0; ex_store = 1'b0;
  endtask

  // Step falling edges until commit_o; lat = cycles waited (0 on timeout).
  task automatic wait_commit(input int budget, output int lat);
    lat = 0;
    for (int c = 1; c <= budget; c++) begin
      if (commit_o === 1'b1) begin
        lat = c;
        break;
      end
      @(negedge clk);
    end
  endtask

  // Memory model: accept after 'stall' cycles, respond 'rdelay' cycles later.
  task automatic serve_bus(input int stall, input int rdelay, input logic [63:0] rdata,
                           output bit ok, output logic [63:0] addr, output logic we,
                           output logic [63:0] wdata, output logic [7:0] wmask);
    ok = 1'b0;
    for (int i = 0; i < 4 && bus.mem_req_valid_o !== 1'b1; i++) @(negedge clk);
    addr = bus.mem_addr_o; we = bus.mem_we_o; wdata = bus.mem_wdata_o; wmask = bus.mem_wmask_o;
    if (bus.mem_req_valid_o === 1'b1) begin
      ok = 1'b1;
      for (int i = 0; i < stall; i++) @(negedge clk);
      bus.mem_req_ready_i = 1'b1;
      @(negedge clk);
      bus.mem_req_ready_i = 1'b0;
      for (int i = 0; i < rdelay; i++) @(negedge clk);
      bus.mem_rsp_valid_i = 1'b1; bus.mem_rsp_rdata_i = rdata;
      @(negedge clk);
      bus.mem_rsp_valid_i = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; ex_valid = 1'b0; ex_pc = '0; ex_result = '0; ex_rd = '0; ex_rd_wen = 1'b0;
    ex_load = 1'b0; ex_store = 1'b0; ex_funct3 = '0; ex_sdata = '0;
    bus.mem_req_ready_i = 1'b0; bus.mem_rsp_valid_i = 1'b0; bus.mem_rsp_rdata_i = '0;
    repeat (3) @(negedge clk);
    n_tests++; if (ex_ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_ex_ready got %b exp 1", ex_ready_o); end
    n_tests++; if ({commit_o, reg_wen_o, misalign_o, bus.mem_req_valid_o, bus.mem_we_o} !== 5'b0) begin
      n_fail++; $display("FAIL reset_flags got %b exp 00000", {commit_o, reg_wen_o, misalign_o, bus.mem_req_valid_o, bus.mem_we_o}); end
    n_tests++; if ({reg_wdata_o, commit_pc_o, bus.mem_addr_o, reg_waddr_o, bus.mem_wmask_o} !== '0) begin
      n_fail++; $display("FAIL reset_data got wdata=%h pc=%h addr=%h", reg_wdata_o, commit_pc_o, bus.mem_addr_o); end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_alu();
    exp_t e;
    int lat;
    sb.push_back('{64'h0000_0000_0040_0100, 1'b1, 5'd5, 64'h1234, 1'b0});
    issue(64'h0000_0000_0040_0100, 64'h1234, 5'd5, 1'b1, 1'b0, 1'b0, 3'b000, 64'd0);
    n_tests++; if (ex_ready_o !== 1'b0) begin n_fail++; $display("FAIL alu_ex_ready got %b exp 0", ex_ready_o); end
    wait_commit(6, lat);
    n_tests++; if (lat != 1) begin n_fail++; $display("FAIL alu_latency got %0d exp 1", lat); end
    e = sb.pop_front();
    n_tests++; if (commit_pc_o !== e.pc) begin n_fail++; $display("FAIL alu_pc got %h exp %h", commit_pc_o, e.pc); end
    n_tests++; if (reg_wen_o !== e.wen || reg_waddr_o !== e.waddr) begin
      n_fail++; $display("FAIL alu_wport got wen=%b waddr=%0d exp wen=%b waddr=%0d", reg_wen_o, reg_waddr_o, e.wen, e.waddr); end
    n_tests++; if (reg_wdata_o !== e.wdata) begin n_fail++; $display("FAIL alu_wdata got %h exp %h", reg_wdata_o, e.wdata); end
    @(negedge clk);
    n_tests++; if (commit_o !== 1'b0 || reg_wen_o !== 1'b0 || reg_wdata_o !== 64'h1234) begin
      n_fail++; $display("FAIL alu_after_wb got commit=%b wen=%b wdata=%h exp 0 0 1234", commit_o, reg_wen_o, reg_wdata_o); end
  endtask

  task automatic test_load_extend();
    exp_t e;
    int lat;
    bit ok;
    logic [63:0] a, wd;
    logic we;
    logic [7:0] wm;
    logic [63:0] rd_data;
    rd_data = 64'h0000_0000_80FF_0000;
    for (int k = 0; k < 2; k++) begin
      // k = 0 LB, k = 1 LBU of the same byte
      sb.push_back('{64'h200 + 64'(k*4), 1'b1, 5'd9,
                     (k == 0) ? 64'hFFFF_FFFF_FFFF_FF80 : 64'h0000_0000_0000_0080, 1'b0});
      issue(64'h200 + 64'(k*4), 64'h8000_0003, 5'd9, 1'b1, 1'b1, 1'b0, (k == 0) ? 3'b000 : 3'b100, 64'd0);
      n_tests++; if (commit_o !== 1'b0 || ex_ready_o !== 1'b0) begin
        n_fail++; $display("FAIL load_req_phase got commit=%b ready=%b exp 0 0", commit_o, ex_ready_o); end
      serve_bus(0, 0, rd_data, ok, a, we, wd, wm);
      n_tests++; if (!ok || a !== 64'h8000_0000 || we !== 1'b0) begin
        n_fail++; $display("FAIL load_req got ok=%b addr=%h we=%b exp 1 80000000 0", ok, a, we); end
      wait_commit(4, lat);
      e = sb.pop_front();
      n_tests++; if (lat != 1 || reg_wen_o !== e.wen || reg_wdata_o !== e.wdata || commit_pc_o !== e.pc) begin
        n_fail++; $display("FAIL load_extend_%0d got lat=%0d wen=%b wdata=%h pc=%h exp wdata=%h pc=%h",
                           k, lat, reg_wen_o, reg_wdata_o, commit_pc_o, e.wdata, e.pc); end
    end
  endtask

  task automatic test_store_stall();
    exp_t e;
    int lat;
    sb.push_back('{64'h300, 1'b0, 5'd3, 64'd0, 1'b0});
    issue(64'h300, 64'h8000_0006, 5'd3, 1'b1, 1'b0, 1'b1, 3'b001, 64'hABCD);
    for (int i = 0; i < 4; i++) begin
      if (i == 3) bus.mem_req_ready_i = 1'b1;
      n_tests++;
      if (bus.mem_req_valid_o !== 1'b1 || bus.mem_addr_o !== 64'h8000_0000 || bus.mem_we_o !== 1'b1 ||
          bus.mem_wmask_o !== 8'hC0 || bus.mem_wdata_o !== 64'hABCD_0000_0000_0000) begin
        n_fail++; $display("FAIL store_req_%0d got v=%b addr=%h we=%b mask=%h wdata=%h exp 1 80000000 1 c0 abcd000000000000",
                           i, bus.mem_req_valid_o, bus.mem_addr_o, bus.mem_we_o, bus.mem_wmask_o, bus.mem_wdata_o); end
      @(negedge clk);
    end
    bus.mem_req_ready_i = 1'b0;
    n_tests++; if (bus.mem_req_valid_o !== 1'b0) begin n_fail++; $display("FAIL store_wait_valid got %b exp 0", bus.mem_req_valid_o); end
    bus.mem_rsp_valid_i = 1'b1;
    @(negedge clk);
    bus.mem_rsp_valid_i = 1'b0;
    wait_commit(4, lat);
    e = sb.pop_front();
    n_tests++; if (lat != 1 || reg_wen_o !== e.wen || commit_pc_o !== e.pc || misalign_o !== 1'b0) begin
      n_fail++; $display("FAIL store_commit got lat=%0d wen=%b pc=%h mis=%b exp 1 0 %h 0", lat, reg_wen_o, commit_pc_o, misalign_o, e.pc); end
  endtask

  task automatic test_misalign();
    exp_t e;
    int lat;
    sb.push_back('{64'h400, 1'b0, 5'd4, 64'd0, 1'b1});
    issue(64'h400, 64'h8000_0002, 5'd4, 1'b1, 1'b1, 1'b0, 3'b010, 64'd0);
    wait_commit(3, lat);
    e = sb.pop_front();
    n_tests++; if (lat != 1 || misalign_o !== e.mis || reg_wen_o !== e.wen || commit_pc_o !== e.pc) begin
      n_fail++; $display("FAIL misalign_commit got lat=%0d mis=%b wen=%b pc=%h exp 1 1 0 %h", lat, misalign_o, reg_wen_o, commit_pc_o, e.pc); end
    for (int i = 0; i < 3; i++) begin
      n_tests++; if (bus.mem_req_valid_o !== 1'b0) begin n_fail++; $display("FAIL misalign_no_req got %b exp 0", bus.mem_req_valid_o); end
      @(negedge clk);
    end
    n_tests++; if (misalign_o !== 1'b0 || commit_o !== 1'b0) begin
      n_fail++; $display("FAIL misalign_clear got mis=%b commit=%b exp 0 0", misalign_o, commit_o); end
  endtask

  task automatic test_rd_zero();
    exp_t e;
    int lat;
    bit ok;
    logic [63:0] a, wd;
    logic we;
    logic [7:0] wm;
    sb.push_back('{64'h500, 1'b0, 5'd0, 64'd0, 1'b0});
    issue(64'h500, 64'h8000_0018, 5'd0, 1'b1, 1'b1, 1'b0, 3'b011, 64'd0);
    serve_bus(1, 1, 64'h0123_4567_89AB_CDEF, ok, a, we, wd, wm);
    n_tests++; if (!ok || a !== 64'h8000_0018 || we !== 1'b0) begin
      n_fail++; $display("FAIL rd0_req got ok=%b addr=%h we=%b exp 1 80000018 0", ok, a, we); end
    wait_commit(4, lat);
    e = sb.pop_front();
    n_tests++; if (lat != 1 || reg_wen_o !== e.wen || commit_pc_o !== e.pc) begin
      n_fail++; $display("FAIL rd0_commit got lat=%0d wen=%b pc=%h exp 1 0 %h", lat, reg_wen_o, commit_pc_o, e.pc); end
  endtask

  task automatic test_back_to_back();
    // ex_valid held high across two ALU ops: the second retires two cycles later
    @(negedge clk);
    ex_valid = 1'b1; ex_pc = 64'h600; ex_result = 64'hAAAA; ex_rd = 5'd1; ex_rd_wen = 1'b1;
    ex_load = 1'b0; ex_store = 1'b0; ex_funct3 = 3'b000;
    @(negedge clk);
    n_tests++; if (commit_o !== 1'b1 || commit_pc_o !== 64'h600 || reg_wdata_o !== 64'hAAAA) begin
      n_fail++; $display("FAIL b2b_first got commit=%b pc=%h wdata=%h exp 1 600 aaaa", commit_o, commit_pc_o, reg_wdata_o); end
    ex_pc = 64'h604; ex_result = 64'hBBBB; ex_rd = 5'd2;
    @(negedge clk);
    n_tests++; if (commit_o !== 1'b0 || ex_ready_o !== 1'b1) begin
      n_fail++; $display("FAIL b2b_gap got commit=%b ready=%b exp 0 1", commit_o, ex_ready_o); end
    @(negedge clk);
    ex_valid = 1'b0;
    n_tests++; if (commit_o !== 1'b1 || commit_pc_o !== 64'h604 || reg_waddr_o !== 5'd2 || reg_wdata_o !== 64'hBBBB) begin
      n_fail++; $display("FAIL b2b_second got commit=%b pc=%h waddr=%0d wdata=%h exp 1 604 2 bbbb", commit_o, commit_pc_o, reg_waddr_o, reg_wdata_o); end
    @(negedge clk);
  endtask

  task automatic test_random_mix();
    exp_t e;
    int lat, kind, off, n;
    bit ok;
    logic [63:0] a, wd, addr, rdata, sdata, pc;
    logic we, rwen;
    logic [7:0] wm;
    logic [2:0] f3;
    logic [4:0] rd;
    for (int t = 0; t < 30; t++) begin
      kind = $urandom_range(0, 2);
      f3 = (kind == 2) ? 3'($urandom_range(0, 3)) : 3'($urandom_range(0, 7));
      n = 1 << f3[1:0];
      off = $urandom_range(0, 8/n - 1) * n;
      addr = {$urandom, $urandom};
      addr[2:0] = 3'(off);
      rdata = {$urandom, $urandom};
      sdata = {$urandom, $urandom};
      pc = {32'd0, $urandom} & ~64'd3;
      rd = 5'($urandom_range(0, 31));
      rwen = 1'($urandom_range(0, 1));
      e.pc = pc; e.waddr = rd; e.mis = 1'b0;
      e.wen = rwen && (kind != 2) && (rd != 5'd0) && !(kind == 1 && f3 == 3'b111);
      e.wdata = (kind == 0) ? addr : model_load(rdata, off, f3);
      sb.push_back(e);
      issue(pc, addr, rd, rwen, kind == 1, kind == 2, f3, sdata);
      if (kind != 0) begin
        serve_bus($urandom_range(0, 2), $urandom_range(0, 2), rdata, ok, a, we, wd, wm);
        n_tests++; if (!ok || a !== {addr[63:3], 3'b000} || we !== (kind == 2)) begin
          n_fail++; $display("FAIL rand_req_%0d got ok=%b addr=%h we=%b exp addr=%h", t, ok, a, we, {addr[63:3], 3'b000}); end
        if (kind == 2) begin
          n_tests++; if (wm !== model_mask(off, f3) || wd !== model_wdata(sdata, off)) begin
            n_fail++; $display("FAIL rand_store_%0d got mask=%h wdata=%h exp mask=%h wdata=%h",
                               t, wm, wd, model_mask(off, f3), model_wdata(sdata, off)); end
        end
      end
      wait_commit(4, lat);
      e = sb.pop_front();
      n_tests++; if (lat == 0 || commit_pc_o !== e.pc || reg_wen_o !== e.wen || misalign_o !== e.mis ||
                     (e.wen && (reg_waddr_o !== e.waddr || reg_wdata_o !== e.wdata))) begin
        n_fail++; $display("FAIL rand_commit_%0d kind=%0d f3=%0d got lat=%0d pc=%h wen=%b waddr=%0d wdata=%h exp pc=%h wen=%b waddr=%0d wdata=%h",
                           t, kind, f3, lat, commit_pc_o, reg_wen_o, reg_waddr_o, reg_wdata_o, e.pc, e.wen, e.waddr, e.wdata); end
    end
  endtask

  task automatic test_reset_in_wait();
    issue(64'h700, 64'h8000_0010, 5'd7, 1'b1, 1'b1, 1'b0, 3'b011, 64'd0);
    bus.mem_req_ready_i = 1'b1;
    @(negedge clk);
    bus.mem_req_ready_i = 1'b0;
    n_tests++; if (bus.mem_req_valid_o !== 1'b0 || commit_o !== 1'b0 || ex_ready_o !== 1'b0) begin
      n_fail++; $display("FAIL rstw_in_wait got v=%b commit=%b ready=%b exp 0 0 0", bus.mem_req_valid_o, commit_o, ex_ready_o); end
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    n_tests++; if (ex_ready_o !== 1'b1 || {commit_o, reg_wen_o, misalign_o, bus.mem_req_valid_o, bus.mem_we_o} !== 5'b0) begin
      n_fail++; $display("FAIL rstw_flags got ready=%b flags=%b exp 1 00000", ex_ready_o,
                         {commit_o, reg_wen_o, misalign_o, bus.mem_req_valid_o, bus.mem_we_o}); end
    n_tests++; if ({reg_wdata_o, commit_pc_o, bus.mem_addr_o, bus.mem_wdata_o, reg_waddr_o, bus.mem_wmask_o} !== '0) begin
      n_fail++; $display("FAIL rstw_data got wdata=%h pc=%h addr=%h waddr=%0d exp all 0", reg_wdata_o, commit_pc_o, bus.mem_addr_o, reg_waddr_o); end
    bus.mem_rsp_valid_i = 1'b1; bus.mem_rsp_rdata_i = 64'hDEAD_BEEF_DEAD_BEEF;
    @(negedge clk);
    bus.mem_rsp_valid_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_tests++; if (commit_o !== 1'b0 || reg_wen_o !== 1'b0 || ex_ready_o !== 1'b1) begin
        n_fail++; $display("FAIL rstw_late_rsp got commit=%b wen=%b ready=%b exp 0 0 1", commit_o, reg_wen_o, ex_ready_o); end
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_load_extend();
    test_store_stall();
    test_misalign();
    test_rd_zero();
    test_back_to_back();
    test_random_mix();
    test_reset_in_wait();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_wb.md
Name: mem_wb

Overview:
- Memory-access/write-back stage between the execute stage and the register file.
- Accepts one retiring instruction from execute, performs any load/store over a valid/ready data-memory bus, and aligns and extends load data.
- Drives the register-file write port (waddr/wdata/wen) plus a one-cycle commit pulse with the retiring PC.

Parameters:
- XLEN, 64, datapath and address width; only 64 is supported.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-low
- ex_valid_i  in  1  execute has an instruction to retire
- ex_ready_o  out  1  stage can accept; high only in IDLE
- ex_pc_i  in  XLEN  instruction address
- ex_result_i  in  XLEN  ALU result; this is the effective address for load/store
- ex_rd_i  in  5  destination register
- ex_rd_wen_i  in  1  instruction writes rd
- ex_load_i  in  1  load instruction
- ex_store_i  in  1  store instruction
- ex_funct3_i  in  3  RISC-V size/sign code
- ex_sdata_i  in  XLEN  store data (rs2)
- mem_req_valid_o  out  1  bus request valid
- mem_req_ready_i  in  1  bus accepts the request
- mem_addr_o  out  XLEN  8-byte-aligned address (addr with bits [2:0] cleared)
- mem_we_o  out  1  1 = write
- mem_wdata_o  out  XLEN  lane-shifted store data
- mem_wmask_o  out  8  byte-enable mask
- mem_rsp_valid_i  in  1  read/write completion
- mem_rsp_rdata_i  in  XLEN  read data (full doubleword)
- reg_waddr_o  out  5  to register file
- reg_wdata_o  out  XLEN  to register file
- reg_wen_o  out  1  to register file
- commit_o  out  1  one-cycle retire pulse
- commit_pc_o  out  XLEN  PC of the retiring instruction
- misalign_o  out  1  accompanies commit_o; the access was misaligned

Behaviour:
- Reset (rst == 0 at a clk edge):
  - state goes to IDLE.
  - All outputs go to 0, except ex_ready_o = 1.
  - Any outstanding bus request is abandoned; late responses are ignored while in IDLE.
- FSM states: IDLE, REQ, WAIT, WB.
- IDLE:
  - ex_ready_o = 1.
  - On ex_valid_i, latch all ex_* inputs.
  - If neither load nor store: go to WB.
  - If misaligned: go to WB. Misaligned means halfword with addr[0] != 0, word with addr[1:0] != 0, or doubleword with addr[2:0] != 0.
  - Otherwise: go to REQ.
- REQ:
  - mem_req_valid_o = 1, with addr/we/wdata/wmask held stable until mem_req_ready_i.
  - On ready, go to WAIT.
- WAIT:
  - On mem_rsp_valid_i, capture the aligned and extended data and go to WB.
  - The response never arrives earlier than the cycle after request acceptance.
- WB (exactly one cycle):
  - commit_o = 1 and commit_pc_o = latched PC.
  - reg_wen_o = rd_wen && !store && !misalign && rd != 0.
  - Go to IDLE.
- Latency from ex handshake to commit:
  - Non-memory instruction: 1 cycle.
  - Memory access: 3 cycles plus bus stall cycles.
  - Throughput is at most 1 instruction per 2 cycles.
- Store lane logic, with off = addr[2:0]:
  - funct3 000/001/010/011 uses base mask 0x01/0x03/0x0F/0xFF.
  - mem_wmask_o = base mask << off.
  - mem_wdata_o = sdata << (8*off).
- Load extract: shifted = rdata >> (8*off), then extend per funct3:
  - 000 LB: sign-extend [7:0]
  - 001 LH: sign-extend [15:0]
  - 010 LW: sign-extend [31:0]
  - 011 LD: full 64 bits
  - 100 LBU, 101 LHU, 110 LWU: zero-extend [7:0] / [15:0] / [31:0]
  - 111: result 0, no write.
- Misaligned access:
  - No bus transaction is issued.
  - commit_o and misalign_o are both asserted and reg_wen_o = 0.
- Non-memory instruction: reg_wdata_o = ex_result_i.
- rd = 0: commits normally with reg_wen_o = 0.
- Outside WB: reg_wen_o, commit_o and misalign_o are 0; reg_waddr_o and reg_wdata_o hold their last values.

Test Plan:
- ALU retire: ex_valid with result 0x1234 and rd = 5 -> next cycle reg_wen = 1, waddr = 5, wdata = 0x1234, commit_pc = ex_pc; ex_ready = 0 in that cycle.
- LB sign-extend: addr 0x8000_0003, rdata 0x0000_0000_80FF_0000 -> mem_addr 0x8000_0000; wdata 0xFFFF_FFFF_FFFF_FF80. Same access as LBU -> 0x80.
- SH at 0x8000_0006 with sdata 0xABCD, mem_req_ready held low 3 cycles -> request stays stable with wmask 0xC0 and wdata 0xABCD_0000_0000_0000; on commit, reg_wen = 0.
- Misaligned LW at 0x8000_0002 -> no mem_req_valid; commit and misalign both 1; reg_wen = 0.
- LD into rd = 0 -> bus read occurs; commit = 1, reg_wen = 0.
- Reset pulled low while in WAIT -> next cycle IDLE, all outputs 0, ex_ready = 1; a late mem_rsp_valid produces no write.
